// File: rtl/normalizer_pkg.sv
// Shared definitions for the sequential normalizer.
//   state_t  : FSM encoding (IDLE, SHIFT, DONE)
//   LR_LEFT  : direction code, normalize toward bit W-1
//   LR_RIGHT : direction code, normalize toward bit 0
package normalizer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

endpackage

// File: rtl/seq_normalizer.sv
// Sequential normalizer: shifts a captured word one bit per clock toward the
// selected end until the end bit is 1, then reports the normalized word and
// the number of shifts applied (the inverse of the barrel shifter).
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request, sampled only in IDLE
//   a        word to normalize, captured on the accepting edge
//   lr       0 = left (target bit W-1), 1 = right (target bit 0)
//   busy     high on every cycle following a shift edge
//   done     one-cycle result pulse
//   y        normalized word
//   amt      number of single-bit shifts applied
//   zero     captured word was all zeros
module seq_normalizer
    import normalizer_pkg::*;
#(
    parameter int N = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [(2**N)-1:0]  a,
    input  logic               lr,
    output logic               busy,
    output logic               done,
    output logic [(2**N)-1:0]  y,
    output logic [N-1:0]       amt,
    output logic               zero
);

    localparam int W = 2**N;

    state_t         state_r;
    state_t         next_s;
    logic [W-1:0]   sreg_r;
    logic [N-1:0]   cnt_r;
    logic           lr_r;
    logic           target_bit_s;
    logic           a_zero_s;
    logic           busy_d_s;
    logic           done_d_s;
    logic           busy_r;
    logic           done_r;
    logic [W-1:0]   y_r;
    logic [N-1:0]   amt_r;
    logic           zero_r;

    assign a_zero_s     = (a == {W{1'b0}});
    assign target_bit_s = (lr_r == LR_LEFT) ? sreg_r[W-1] : sreg_r[0];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_s = a_zero_s ? DONE : SHIFT;
                end else begin
                    next_s = IDLE;
                end
            end
            SHIFT: begin
                if (target_bit_s) begin
                    next_s = DONE;
                end else begin
                    next_s = SHIFT;
                end
            end
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Output decode: busy follows each edge that performs a shift, so it is
    // high for exactly amt cycles and never overlaps done.
    always_comb begin
        busy_d_s = 1'b0;
        done_d_s = 1'b0;
        if (state_r == SHIFT) begin
            busy_d_s = ~target_bit_s;
        end else begin
            busy_d_s = 1'b0;
        end
        if (next_s == DONE) begin
            done_d_s = 1'b1;
        end else begin
            done_d_s = 1'b0;
        end
    end

    // Handshake output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_d_s;
            done_r <= done_d_s;
        end
    end

    // Shift register, shift counter and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg_r <= {W{1'b0}};
            cnt_r  <= {N{1'b0}};
            lr_r   <= 1'b0;
            y_r    <= {W{1'b0}};
            amt_r  <= {N{1'b0}};
            zero_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !a_zero_s) begin
                        sreg_r <= a;
                        lr_r   <= lr;
                        cnt_r  <= {N{1'b0}};
                    end else if (start) begin
                        // All-zero word: nothing to shift, report immediately.
                        y_r    <= {W{1'b0}};
                        amt_r  <= {N{1'b0}};
                        zero_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (target_bit_s) begin
                        y_r    <= sreg_r;
                        amt_r  <= cnt_r;
                        zero_r <= 1'b0;
                    end else begin
                        // A nonzero word hits its target within W-1 shifts,
                        // so the counter cannot wrap here.
                        sreg_r <= (lr_r == LR_LEFT) ? {sreg_r[W-2:0], 1'b0}
                                                    : {1'b0, sreg_r[W-1:1]};
                        cnt_r  <= cnt_r + N'(1);
                    end
                end
                DONE: begin
                    sreg_r <= sreg_r;
                end
                default: begin
                    sreg_r <= sreg_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign y    = y_r;
    assign amt  = amt_r;
    assign zero = zero_r;

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer (N=3, W=8): directed test-plan
// cases, handshake protocol cases and randomized requests, each compared
// against an arithmetic reference model.
module tb_seq_normalizer;

    localparam int N = 3;
    localparam int W = 8;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  a;
    logic          lr;
    logic          busy;
    logic          done;
    logic [W-1:0]  y;
    logic [N-1:0]  amt;
    logic          zero;

    int checks = 0;
    int errors = 0;

    seq_normalizer #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .lr      (lr),
        .busy    (busy),
        .done    (done),
        .y       (y),
        .amt     (amt),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: shift count from the position of the leading/trailing one.
    function automatic int model_amt(input logic [W-1:0] av, input logic lrv);
        int v;
        v = int'(av);
        if (v == 0) return 0;
        if (lrv == 1'b0) return W - $clog2(v + 1);
        return $clog2(v & -v);
    endfunction

    function automatic logic [W-1:0] model_y(input logic [W-1:0] av, input logic lrv);
        int s;
        s = model_amt(av, lrv);
        return lrv ? (av >> s) : (av << s);
    endfunction

    // Issue one request from IDLE and check the full result and timing.
    task automatic run_op(input logic [W-1:0] av, input logic lrv);
        int c;
        int bc;
        bit seen;
        int eamt;
        logic [W-1:0] cap_a;
        cap_a = av;
        eamt  = model_amt(av, lrv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        lr    = lrv;
        @(posedge clk);
        #1;
        c = 0; bc = 0; seen = 1'b0;
        while (c <= W + 2) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bc++;
            // Inputs after capture must not matter; start is ignored here.
            start = 1'($urandom);
            a     = W'($urandom);
            lr    = 1'($urandom);
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(c), (cap_a == '0) ? 32'd0 : 32'(eamt + 1));
        check("busy_cycles", 32'(bc), (cap_a == '0) ? 32'd0 : 32'(eamt));
        check("busy_with_done", 32'(busy), 32'd0);
        check("y", 32'(y), 32'(model_y(cap_a, lrv)));
        check("amt", 32'(amt), 32'(eamt));
        check("zero", 32'(zero), (cap_a == '0) ? 32'd1 : 32'd0);
        // Barrel-shift the captured word by the reported amount.
        check("y_xcheck", 32'(y), lrv ? 32'(cap_a >> amt) : 32'(W'(cap_a << amt)));
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
        check("y_hold", 32'(y), 32'(model_y(cap_a, lrv)));
    endtask

    initial begin
        int c;
        bit seen;
        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        lr      = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_amt", 32'(amt), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Directed test-plan cases
        run_op(8'b0001_0110, 1'b0);
        run_op(8'b1100_0110, 1'b1);
        run_op(8'h01, 1'b0);
        run_op(8'h80, 1'b1);
        run_op(8'h80, 1'b0);
        run_op(8'h00, 1'b0);
        run_op(8'h01, 1'b1);

        // start held high, a changed during SHIFT
        @(negedge clk);
        start = 1'b1;
        a     = 8'h01;
        lr    = 1'b0;
        @(posedge clk);
        #1;
        c = 0; seen = 1'b0;
        while (c <= W + 2) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            a = W'($urandom);
            @(posedge clk);
            #1;
            c++;
        end
        check("hold_done_seen", 32'(seen), 32'd1);
        check("hold_latency", 32'(c), 32'd8);
        check("hold_y", 32'(y), 32'h80);
        check("hold_amt", 32'(amt), 32'd7);
        a = 8'h00;
        @(posedge clk);
        #1;
        check("hold_idle_gap", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("hold_reaccept_done", 32'(done), 32'd1);
        check("hold_reaccept_zero", 32'(zero), 32'd1);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("hold_end_done", 32'(done), 32'd0);

        // Reset mid-SHIFT after a nonzero result is held
        run_op(8'h20, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a     = 8'h01;
        lr    = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_y", 32'(y), 32'd0);
        check("mid_rst_amt", 32'(amt), 32'd0);
        check("mid_rst_zero", 32'(zero), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", 32'(busy | done), 32'd0);
        run_op(8'b0001_0110, 1'b0);

        // Randomized requests
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            ra = W'($urandom);
            if ((i % 9) == 0) ra = '0;
            run_op(ra, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
